// File: rtl/siphash_pkg.sv
// siphash_pkg: shared constants, types and helpers for the SipHash engine.
//   SIP_C0..SIP_C3 : initialisation vectors XORed with the key halves
//   SIP_FIN_XOR    : constant XORed into v2 before finalization
//   sip_state_t    : control FSM states
//   sip_vec_t      : the 256-bit v0..v3 working state
//   tail_mask()    : byte-enable mask for a partial last word
//   rotl64()       : 64-bit rotate left
package siphash_pkg;

  localparam logic [63:0] SIP_C0      = 64'h736f6d6570736575;
  localparam logic [63:0] SIP_C1      = 64'h646f72616e646f6d;
  localparam logic [63:0] SIP_C2      = 64'h6c7967656e657261;
  localparam logic [63:0] SIP_C3      = 64'h7465646279746573;
  localparam logic [63:0] SIP_FIN_XOR = 64'h00000000000000ff;

  typedef enum logic [2:0] {
    IDLE, ACCEPT, COMP, PAD, FIN_INIT, FINAL, DONE
  } sip_state_t;

  typedef struct packed {
    logic [63:0] v3;
    logic [63:0] v2;
    logic [63:0] v1;
    logic [63:0] v0;
  } sip_vec_t;

  // Keep bytes [0 .. bytes-1]; bytes >= 8 keeps the whole word.
  function automatic logic [63:0] tail_mask(input logic [3:0] bytes);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++)
      if (4'(i) < bytes) mask[8*i +: 8] = 8'hff;
    return mask;
  endfunction

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned s);
    return (x << s) | (x >> (64 - s));
  endfunction

endpackage

// File: rtl/sip_round.sv
// sip_round: one combinational SipRound (ARX network) over v0..v3.
//   v      : state in
//   v_next : state after one round
module sip_round
  import siphash_pkg::*;
(
  input  sip_vec_t v,
  output sip_vec_t v_next
);

  logic [63:0] a0, a1, a2, a3;

  always_comb begin
    a0 = v.v0;
    a1 = v.v1;
    a2 = v.v2;
    a3 = v.v3;
    a0 = a0 + a1; a1 = rotl64(a1, 13); a1 = a1 ^ a0; a0 = rotl64(a0, 32);
    a2 = a2 + a3; a3 = rotl64(a3, 16); a3 = a3 ^ a2;
    a0 = a0 + a3; a3 = rotl64(a3, 21); a3 = a3 ^ a0;
    a2 = a2 + a1; a1 = rotl64(a1, 17); a1 = a1 ^ a2; a2 = rotl64(a2, 32);
    v_next = '{v3: a3, v2: a2, v1: a1, v0: a0};
  end

endmodule

// File: rtl/siphash_core.sv
// siphash_core: sequential SipHash-c-d engine.
//   clk, rst                         : clock, async active-high reset
//   start, key                       : begin a new hash (IDLE only), latch key
//   msg_valid/ready/data/last/bytes  : 64-bit message word stream
//   hash_valid/ready, hash           : 64-bit tag output
//   busy                             : high whenever not IDLE
// ROUNDS_PER_CYCLE sip_round instances are chained combinationally, so each
// COMP/FINAL cycle advances the state by that many rounds.
module siphash_core
  import siphash_pkg::*;
#(
  parameter int C_ROUNDS         = 2,
  parameter int D_ROUNDS         = 4,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [63:0]  msg_data,
  input  logic         msg_last,
  input  logic [3:0]   msg_bytes,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic [63:0]  hash,
  output logic         busy
);

  localparam int C_CYC = C_ROUNDS / ROUNDS_PER_CYCLE;
  localparam int D_CYC = D_ROUNDS / ROUNDS_PER_CYCLE;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2) ||
      C_ROUNDS < 1 || D_ROUNDS < 1 ||
      (C_ROUNDS % ROUNDS_PER_CYCLE) != 0 || (D_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_param_chk
    $error("siphash_core: ROUNDS_PER_CYCLE must be 1 or 2 and divide C_ROUNDS and D_ROUNDS");
  end

  sip_state_t  state;
  sip_vec_t    v;
  sip_vec_t    vr;        // v after ROUNDS_PER_CYCLE rounds
  logic [63:0] m;         // block being compressed, XORed into v0 at the end
  logic [63:0] count;     // message byte count, only [7:0] reaches the tag
  logic        lastblk;   // current block carries the length byte
  logic        padpend;   // full last word: a length-only block follows
  logic [7:0]  rnd;
  logic [3:0]  eff_bytes;
  logic [63:0] m_in;
  logic [63:0] m_pad;

  // Round chain
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
    sip_vec_t s_in, s_out;
    if (g == 0) begin : g_first
      assign s_in = v;
    end else begin : g_next
      assign s_in = g_rnd[g-1].s_out;
    end
    sip_round u_round (.v(s_in), .v_next(s_out));
  end
  assign vr = g_rnd[ROUNDS_PER_CYCLE-1].s_out;

  // Incoming word: non-last words are always 8 bytes; a last word over 8
  // saturates. A short last word gets its tail masked and the length byte
  // merged into the top byte (which the mask has already cleared).
  always_comb begin
    eff_bytes = 4'd8;
    if (msg_last && msg_bytes < 4'd8) eff_bytes = msg_bytes;
    m_in = msg_data;
    if (msg_last && eff_bytes != 4'd8)
      m_in = (msg_data & tail_mask(eff_bytes)) |
             {count[7:0] + {4'd0, eff_bytes}, 56'd0};
  end

  assign m_pad = {count[7:0], 56'd0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      v          <= '0;
      m          <= '0;
      count      <= '0;
      lastblk    <= 1'b0;
      padpend    <= 1'b0;
      rnd        <= '0;
      msg_ready  <= 1'b0;
      hash_valid <= 1'b0;
      hash       <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          v         <= '{v3: key[127:64] ^ SIP_C3, v2: key[63:0] ^ SIP_C2,
                         v1: key[127:64] ^ SIP_C1, v0: key[63:0] ^ SIP_C0};
          count     <= '0;
          lastblk   <= 1'b0;
          padpend   <= 1'b0;
          rnd       <= '0;
          msg_ready <= 1'b1;
          busy      <= 1'b1;
          state     <= ACCEPT;
        end
        ACCEPT: if (msg_valid) begin
          v.v3      <= v.v3 ^ m_in;
          m         <= m_in;
          count     <= count + {60'd0, eff_bytes};
          if (msg_last) begin
            if (eff_bytes == 4'd8) padpend <= 1'b1;
            else                   lastblk <= 1'b1;
          end
          rnd       <= '0;
          msg_ready <= 1'b0;
          state     <= COMP;
        end
        COMP: begin
          v   <= vr;
          rnd <= rnd + 8'd1;
          if (rnd == 8'(C_CYC - 1)) begin
            v.v0 <= vr.v0 ^ m;
            rnd  <= '0;
            if (padpend) begin
              padpend <= 1'b0;
              state   <= PAD;
            end else if (lastblk) begin
              state   <= FIN_INIT;
            end else begin
              msg_ready <= 1'b1;
              state     <= ACCEPT;
            end
          end
        end
        PAD: begin
          v.v3    <= v.v3 ^ m_pad;
          m       <= m_pad;
          lastblk <= 1'b1;
          state   <= COMP;
        end
        FIN_INIT: begin
          v.v2  <= v.v2 ^ SIP_FIN_XOR;
          rnd   <= '0;
          state <= FINAL;
        end
        FINAL: begin
          v   <= vr;
          rnd <= rnd + 8'd1;
          if (rnd == 8'(D_CYC - 1)) begin
            hash       <= vr.v0 ^ vr.v1 ^ vr.v2 ^ vr.v3;
            hash_valid <= 1'b1;
            rnd        <= '0;
            state      <= DONE;
          end
        end
        DONE: if (hash_ready) begin
          hash_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siphash_core.sv
// tb_siphash_core: directed checks of siphash_core (SipHash-2-4) with one
// instance per ROUNDS_PER_CYCLE value (index 0 -> R=1, index 1 -> R=2).
module tb_siphash_core;

  localparam logic [127:0] KEY     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [63:0]  H_EMPTY = 64'h726fdb47dd0e0e31;
  localparam logic [63:0]  H_8     = 64'h93f5f5799a932462;
  localparam logic [63:0]  H_15    = 64'ha129ca6149be45e5;

  logic             clk = 1'b0;
  logic             rst;
  logic [127:0]     key;
  logic [1:0]       start, msg_valid, msg_last, hash_ready;
  logic [1:0][63:0] msg_data;
  logic [1:0][3:0]  msg_bytes;
  logic [1:0]       msg_ready, hash_valid, busy;
  logic [1:0][63:0] hash;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    siphash_core #(.C_ROUNDS(2), .D_ROUNDS(4), .ROUNDS_PER_CYCLE(g + 1)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .key(key),
      .msg_valid(msg_valid[g]), .msg_ready(msg_ready[g]), .msg_data(msg_data[g]),
      .msg_last(msg_last[g]), .msg_bytes(msg_bytes[g]),
      .hash_valid(hash_valid[g]), .hash_ready(hash_ready[g]), .hash(hash[g]),
      .busy(busy[g])
    );
  end

  // Message byte i is i mod 256; bytes past the end are 0xff garbage.
  function automatic logic [63:0] word_of(input int n, input int w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++)
      r[8*b +: 8] = (8*w + b < n) ? 8'(8*w + b) : 8'hff;
    return r;
  endfunction

  function automatic logic [63:0] rl(input logic [63:0] x, input int s);
    return (x << s) | (x >> (64 - s));
  endfunction

  // Software SipHash-2-4 reference over the byte pattern above.
  function automatic logic [63:0] ref_hash(input int n);
    logic [63:0] k0, k1, v0, v1, v2, v3, m;
    int nb;
    k0 = KEY[63:0];
    k1 = KEY[127:64];
    v0 = k0 ^ 64'h736f6d6570736575;
    v1 = k1 ^ 64'h646f72616e646f6d;
    v2 = k0 ^ 64'h6c7967656e657261;
    v3 = k1 ^ 64'h7465646279746573;
    nb = n / 8;
    for (int w = 0; w <= nb + 1; w++) begin
      if (w <= nb) begin
        m = '0;
        for (int b = 0; b < 8; b++)
          if (8*w + b < n) m[8*b +: 8] = 8'(8*w + b);
        if (w == nb) m[63:56] = 8'(n);
        v3 ^= m;
      end else begin
        m = '0;
        v2 ^= 64'hff;
      end
      for (int r = 0; r < ((w <= nb) ? 2 : 4); r++) begin
        v0 += v1; v1 = rl(v1, 13); v1 ^= v0; v0 = rl(v0, 32);
        v2 += v3; v3 = rl(v3, 16); v3 ^= v2;
        v0 += v3; v3 = rl(v3, 21); v3 ^= v0;
        v2 += v1; v1 = rl(v1, 17); v1 ^= v2; v2 = rl(v2, 32);
      end
      if (w <= nb) v0 ^= m;
    end
    return v0 ^ v1 ^ v2 ^ v3;
  endfunction

  // Cycles from the start-sampling edge (counted as 1) to hash_valid.
  function automatic int exp_lat(input int n, input int r);
    int words, pad;
    words = (n == 0) ? 1 : (n + 7) / 8;
    pad   = (n > 0 && n % 8 == 0) ? 1 : 0;
    return 1 + (words + pad) * (1 + 2 / r) + 1 + 4 / r;
  endfunction

  // Drives one full hash on instance d and reports what was seen.
  task automatic run_hash(input int d, input int n, input int last_bytes,
                          input bit bp, input int hold,
                          output logic [63:0] tag, output int lat, output bit got,
                          output int unstable, output int ready_err, output bit released);
    int words, lb, w, cyc;
    bit fire;
    words = (n == 0) ? 1 : (n + 7) / 8;
    lb    = n - 8 * (words - 1);
    if (last_bytes >= 0) lb = last_bytes;
    w = 0; got = 0; lat = 0; tag = '0; unstable = 0; ready_err = 0; released = 0;
    @(negedge clk);
    start[d] = 1'b1; msg_valid[d] = 1'b0; hash_ready[d] = 1'b0;
    @(negedge clk);
    start[d] = 1'b0;
    cyc = 1;
    while (!got && cyc < 3000) begin
      if (w < words) begin
        msg_valid[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        msg_data[d]  = word_of(n, w);
        msg_last[d]  = (w == words - 1);
        msg_bytes[d] = (w == words - 1) ? 4'(lb) : 4'd0;
      end else begin
        msg_valid[d] = 1'b0;
      end
      start[d] = bp && (cyc == 3);
      fire = msg_valid[d] & msg_ready[d];
      @(negedge clk);
      cyc++;
      if (fire) begin
        w++;
        if (msg_ready[d]) ready_err++;
      end
      if (hash_valid[d]) begin
        got = 1; lat = cyc; tag = hash[d];
      end
    end
    msg_valid[d] = 1'b0;
    start[d]     = 1'b0;
    if (got) begin
      repeat (hold) begin
        @(negedge clk);
        if (hash_valid[d] !== 1'b1 || hash[d] !== tag) unstable++;
      end
      hash_ready[d] = 1'b1;
      @(negedge clk);
      hash_ready[d] = 1'b0;
      released = (hash_valid[d] === 1'b0) && (busy[d] === 1'b0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; key = KEY;
    start = '0; msg_valid = '0; msg_last = '0; hash_ready = '0;
    msg_data = '0; msg_bytes = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (msg_ready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_msg_ready[%0d]: got %b want 0", d, msg_ready[d]); end
      n_checks++; if (hash_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_hash_valid[%0d]: got %b want 0", d, hash_valid[d]); end
      n_checks++; if (hash[d] !== 64'd0) begin n_fail++; $display("FAIL reset_hash[%0d]: got %h want 0", d, hash[d]); end
      n_checks++; if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector(input string name, input int n, input int lbo, input logic [63:0] exp);
    logic [63:0] tag; int lat, uns, rerr; bit got, rel;
    for (int d = 0; d < 2; d++) begin
      run_hash(d, n, lbo, 1'b0, 0, tag, lat, got, uns, rerr, rel);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL %s_timeout[R=%0d]: no hash_valid", name, d + 1); end
      n_checks++; if (tag !== exp) begin n_fail++; $display("FAIL %s_hash[R=%0d]: got %h want %h", name, d + 1, tag, exp); end
      n_checks++; if (lat != exp_lat(n, d + 1)) begin n_fail++; $display("FAIL %s_latency[R=%0d]: got %0d want %0d", name, d + 1, lat, exp_lat(n, d + 1)); end
      n_checks++; if (rerr != 0) begin n_fail++; $display("FAIL %s_ready_in_comp[R=%0d]: got %0d want 0", name, d + 1, rerr); end
      n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL %s_release[R=%0d]: got %b want 1", name, d + 1, rel); end
    end
  endtask

  task automatic test_empty;    test_vector("empty", 0, -1, H_EMPTY); endtask
  task automatic test_one_word; test_vector("word8", 8, -1, H_8);     endtask
  task automatic test_saturate; test_vector("sat15", 8, 15, H_8);     endtask
  task automatic test_tail15;   test_vector("tail15", 15, -1, H_15);  endtask
  task automatic test_long;     test_vector("len300", 300, -1, ref_hash(300)); endtask

  task automatic test_backpressure;
    logic [63:0] tag, exp; int lat, uns, rerr, n; bit got, rel;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 3; s++) begin
        n   = (s == 0) ? 0 : (s == 1) ? 8 : 15;
        exp = (s == 0) ? H_EMPTY : (s == 1) ? H_8 : H_15;
        run_hash(d, n, -1, 1'b1, 20, tag, lat, got, uns, rerr, rel);
        n_checks++; if (tag !== exp) begin n_fail++; $display("FAIL bp_hash[R=%0d,n=%0d]: got %h want %h", d + 1, n, tag, exp); end
        n_checks++; if (uns != 0) begin n_fail++; $display("FAIL bp_stable[R=%0d,n=%0d]: got %0d unstable cycles want 0", d + 1, n, uns); end
        n_checks++; if (rerr != 0) begin n_fail++; $display("FAIL bp_ready_in_comp[R=%0d,n=%0d]: got %0d want 0", d + 1, n, rerr); end
        n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL bp_release[R=%0d,n=%0d]: got %b want 1", d + 1, n, rel); end
      end
  endtask

  task automatic test_reset_mid;
    logic [63:0] tag; int lat, uns, rerr; bit got, rel, seen;
    @(negedge clk);
    start[0] = 1'b1; msg_valid[0] = 1'b1; msg_data[0] = word_of(0, 0);
    msg_last[0] = 1'b1; msg_bytes[0] = 4'd0;
    @(negedge clk);            // now in ACCEPT
    start[0] = 1'b0;
    @(negedge clk);            // word taken, now in COMP
    msg_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy[0]); end
    n_checks++; if (hash[0] !== 64'd0) begin n_fail++; $display("FAIL midrst_hash: got %h want 0", hash[0]); end
    n_checks++; if (msg_ready[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_msg_ready: got %b want 0", msg_ready[0]); end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (hash_valid[0] !== 1'b0) seen = 1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_valid: got %b want 0", seen); end
    rst = 1'b0;
    @(negedge clk);
    run_hash(0, 0, -1, 1'b0, 0, tag, lat, got, uns, rerr, rel);
    n_checks++; if (tag !== H_EMPTY) begin n_fail++; $display("FAIL midrst_rerun_hash: got %h want %h", tag, H_EMPTY); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_one_word();
    test_saturate();
    test_tail15();
    test_backpressure();
    test_reset_mid();
    test_long();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/siphash_core.md
Name: siphash_core

Overview:
- Sequential SipHash-c-d engine. Streams 64-bit message words into a 256-bit v0..v3 state and runs the configurable compression and finalization round counts.
- Produces the 64-bit tag on a valid/ready output port.
- Sits between the message DMA/word packer and the tag comparator. Wraps the existing combinational sip_round primitive: one or two unrolled rounds per clock.

Parameters:
- C_ROUNDS, 2, compression rounds per message block (>=1)
- D_ROUNDS, 4, finalization rounds (>=1)
- ROUNDS_PER_CYCLE, 1, sip_round instances chained per clock; legal values 1 or 2; must divide C_ROUNDS and D_ROUNDS (elaboration $error otherwise)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches key and begins a new hash; honoured only in IDLE
- key  in  128  k0=key[63:0], k1=key[127:64], little-endian byte order
- msg_valid  in  1  message word valid
- msg_ready  out  1  core accepts word this cycle
- msg_data  in  64  message word, byte 0 in [7:0]
- msg_last  in  1  final word of message
- msg_bytes  in  4  valid bytes in this word (1..8 when last; ignored, treated as 8, otherwise); an empty message is one last word with msg_bytes=0
- hash_valid  out  1  tag available
- hash_ready  in  1  consumer takes tag
- hash  out  64  v0^v1^v2^v3 after finalization
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, v0..v3=0, byte counter=0, round counter=0.
  - msg_ready=0, hash_valid=0, hash=0, busy=0.
- States and transitions:
  - IDLE: on start, set v0=k0^0x736f6d6570736575, v1=k1^0x646f72616e646f6d, v2=k0^0x6c7967656e657261, v3=k1^0x7465646279746573. Go to ACCEPT. start while busy is ignored.
  - ACCEPT: msg_ready=1. On msg_valid&msg_ready:
    - Non-last: m=msg_data; v3^=m; count+=8; go to COMP.
    - Last with msg_bytes<8: m=masked tail bytes | (((count+msg_bytes) mod 256)<<56). Bytes at index>=msg_bytes are zeroed. Set LASTBLK flag and go to COMP.
    - Last with msg_bytes==8: process as a full word, then set PADPEND so a length-only block follows.
  - COMP: apply ROUNDS_PER_CYCLE rounds/cycle for C_ROUNDS/ROUNDS_PER_CYCLE cycles. Then v0^=m and choose the next state:
    - PADPEND: go to PAD.
    - LASTBLK: go to FIN_INIT.
    - Otherwise: go to ACCEPT.
  - PAD: m=(count mod 256)<<56; v3^=m; set LASTBLK; go to COMP. Takes 1 cycle.
  - FIN_INIT: v2^=0xff; go to FINAL. Takes 1 cycle.
  - FINAL: D_ROUNDS/ROUNDS_PER_CYCLE cycles. Then register hash=v0^v1^v2^v3 and go to DONE.
  - DONE: hash_valid=1 and hash stable until hash_ready. On hash_valid&hash_ready go to IDLE in the same cycle; hash_valid drops next cycle.
- msg_ready is 0 outside ACCEPT. The core never accepts a word while compressing.
- Latency, R=ROUNDS_PER_CYCLE: per block = 1 accept cycle + C/R cycles. Tail = (PAD block if any) + 1 + D/R.
  - 2-4, R=1, empty message: start -> hash_valid after 1 (init) + 1 + 2 + 1 + 4 = 9 cycles.
- Byte counter is 64 bits and wraps modulo 2^64; only the low 8 bits are used, so the length field wraps at 256 bytes.
- msg_bytes=0 on a non-last word is treated as 8. msg_bytes>8 on a last word saturates to 8.
- Reset mid-operation aborts immediately. A partially computed tag is never presented.
- All additions modulo 2^64; rotations are as in sip_round.

Decomposition:
- Package siphash_pkg holds:
  - IV constants SIP_C0..SIP_C3
  - finalization constant SIP_FIN_XOR=0xff
  - state enum: IDLE, ACCEPT, COMP, PAD, FIN_INIT, FINAL, DONE
  - helper function tail_mask(bytes)
- Sub-module: the existing sip_round, generate-instantiated ROUNDS_PER_CYCLE times in a chain. No new sub-module.

Test Plan:
- Common setup: key=0x0f0e0d0c0b0a09080706050403020100; 2-4; run with R=1 and R=2.
- Empty message (one last word, msg_bytes=0) -> hash=0x726fdb47dd0e0e31. For R=1, hash_valid exactly 9 cycles after start.
- 8-byte message 0x0706050403020100, last, msg_bytes=8 -> PAD state visited once; hash=0x93f5f5799a932462.
- 15-byte message:
  - Stimulus: word0=0x0706050403020100; word1=0xff0e0d0c0b0a0908, last, msg_bytes=7.
  - Response: garbage byte 0xff is masked; hash=0xa129ca6149be45e5.
- Backpressure:
  - Stimulus: msg_valid toggled randomly; start pulsed while busy; hash_ready held low 20 cycles.
  - Response: no words dropped or duplicated; extra start ignored; hash stable; results identical to the three tag scenarios above.
- Async reset asserted mid-COMP:
  - Response: outputs zero immediately, no hash_valid.
  - A following empty-message run still yields 0x726fdb47dd0e0e31.
- 300-byte message (37 full words + 4-byte tail) -> length byte 0x2c; compare against the software reference model.
